// File: rtl/credit_tx.sv
// credit_tx: stages upstream words and issues them as credit-gated bursts.
// Define CREDIT_TX_STATS_EN to build the word and stall-cycle counters.
module credit_tx #(
    parameter int DEPTH       = 1024,
    parameter int WIDTH       = 32,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int STAGE_DEPTH = 4,
    parameter int BURST_MIN   = 1,
    parameter int BURST_MAX   = 16
) (
    input  logic              re_clk,
    input  logic              re_reset_n,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [WIDTH-1:0]  src_data,
    input  logic [ADDR_W:0]   re_credit,
    output logic              re_valid,
    output logic [WIDTH-1:0]  data_in,
    output logic              tx_busy,
    output logic [31:0]       stat_words,
    output logic [31:0]       stat_stall_cycles
);
    localparam int SW = $clog2(STAGE_DEPTH);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW:0]     STAGE_FULL = STAGE_DEPTH[SW:0];
    localparam logic [ADDR_W:0] BMIN       = BURST_MIN[ADDR_W:0];
    localparam logic [BW-1:0]   BMAX       = BURST_MAX[BW-1:0];

    typedef enum logic [1:0] {IDLE, SEND, STALL, GAP} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [SW:0]       stage_cnt_q, stage_cnt_d;
    logic [SW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [SW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              re_valid_q, re_valid_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              ready_q, ready_d;
    logic [WIDTH-1:0]  mem_q [STAGE_DEPTH];

    logic [ADDR_W:0]   eff;
    logic              has, push, issue;

    always_comb begin
        // eff discounts the write that completes at the coming edge
        eff         = re_credit - (ADDR_W+1)'(re_valid_q);
        has         = (stage_cnt_q != '0);
        push        = src_valid && ready_q;
        issue       = 1'b0;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE:        issue = has && (eff >= BMIN);
            SEND, STALL: issue = has && (eff != '0);
            GAP:         state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        stage_cnt_d = stage_cnt_q + (SW+1)'(push) - (SW+1)'(issue);
        if (issue) begin
            burst_cnt_d = (state_q == IDLE) ? BW'(1) : burst_cnt_q + BW'(1);
            if (burst_cnt_d == BMAX || stage_cnt_d == '0) begin
                state_d     = GAP;
                burst_cnt_d = '0;
            end else begin
                state_d = SEND;
            end
        end else if (state_q == SEND) begin
            state_d = has ? STALL : GAP;
            if (!has) burst_cnt_d = '0;
        end
        wr_ptr_d   = wr_ptr_q + SW'(push);
        rd_ptr_d   = rd_ptr_q + SW'(issue);
        re_valid_d = issue;
        data_d     = issue ? mem_q[rd_ptr_q] : data_q;
        ready_d    = (stage_cnt_d != STAGE_FULL);
    end

    always_ff @(posedge re_clk or negedge re_reset_n) begin
        if (!re_reset_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            stage_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            re_valid_q  <= 1'b0;
            data_q      <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            re_valid_q  <= re_valid_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
        end
    end

    always_ff @(posedge re_clk) begin
        if (push) mem_q[wr_ptr_q] <= src_data;
    end

    assign src_ready = ready_q;
    assign re_valid  = re_valid_q;
    assign data_in   = data_q;
    assign tx_busy   = (state_q != IDLE) || has;

`ifdef CREDIT_TX_STATS_EN
    logic [31:0] words_q, words_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        words_d = words_q + 32'(issue);
        stall_d = stall_q + 32'(state_q == STALL);
    end

    always_ff @(posedge re_clk or negedge re_reset_n) begin
        if (!re_reset_n) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_d;
            stall_q <= stall_d;
        end
    end

    assign stat_words        = words_q;
    assign stat_stall_cycles = stall_q;
`else
    assign stat_words        = '0;
    assign stat_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_credit_tx.sv
// Bench for credit_tx: queue-based reference model plus directed scenarios.
module tb_credit_tx;
    localparam int SD   = 4;
    localparam int BMAX = 16;
    localparam int BMIN = 1;
`ifdef CREDIT_TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] src_data;
    logic [10:0] re_credit;
    logic        re_valid;
    logic [31:0] data_in;
    logic        tx_busy;
    logic [31:0] stat_words;
    logic [31:0] stat_stall_cycles;

    logic        src_valid2;
    logic        src_ready2;
    logic [31:0] src_data2;
    logic [10:0] cred2;
    logic        re_valid2;
    logic [31:0] data_in2;
    logic        tx_busy2;
    logic [31:0] sw2;
    logic [31:0] ss2;

    int cred_limit;
    int used;
    assign re_credit = 11'(cred_limit - used);

    credit_tx dut (
        .re_clk(clk), .re_reset_n(rst_n),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .re_credit(re_credit), .re_valid(re_valid), .data_in(data_in),
        .tx_busy(tx_busy), .stat_words(stat_words),
        .stat_stall_cycles(stat_stall_cycles)
    );

    credit_tx #(.BURST_MIN(8)) dut2 (
        .re_clk(clk), .re_reset_n(rst_n),
        .src_valid(src_valid2), .src_ready(src_ready2), .src_data(src_data2),
        .re_credit(cred2), .re_valid(re_valid2), .data_in(data_in2),
        .tx_busy(tx_busy2), .stat_words(sw2), .stat_stall_cycles(ss2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: staged words in a queue, burst phase as a small int.
    // 0 idle, 1 bursting, 2 starved, 3 gap.
    logic [31:0] m_q[$];
    int          m_st;
    int          m_bc;
    bit          exp_valid;
    bit          exp_ready;
    logic [31:0] exp_data;
    int unsigned m_words;
    int unsigned m_stall;
    bit          took;

    initial begin
        used = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_st = 0; m_bc = 0;
                exp_valid = 0; exp_ready = 0; exp_data = '0;
                m_words = 0; m_stall = 0;
                took = 0;
                used <= 0;
            end else begin
                int  eff;
                int  n0;
                bit  go;
                took = src_valid && src_ready;
                n0  = m_q.size();
                eff = int'(re_credit) - int'(exp_valid);
                if (exp_valid) used <= used + 1;
                if (m_st == 2) m_stall++;
                go = (m_st != 3) && (n0 > 0) && (eff >= ((m_st == 0) ? BMIN : 1));
                if (src_valid && exp_ready) m_q.push_back(src_data);
                exp_valid = go;
                if (go) begin
                    exp_data = m_q.pop_front();
                    m_words++;
                    m_bc = (m_st == 0) ? 1 : m_bc + 1;
                    if (m_bc == BMAX || m_q.size() == 0) begin
                        m_st = 3; m_bc = 0;
                    end else begin
                        m_st = 1;
                    end
                end else if (m_st == 3) begin
                    m_st = 0;
                end else if (m_st == 1) begin
                    m_st = (n0 > 0) ? 2 : 3;
                    if (n0 == 0) m_bc = 0;
                end
                exp_ready = (m_q.size() != SD);
            end
        end
    end

    int          vec;
    int          err;
    int          nval;
    int          run;
    int          runs[$];
    logic [31:0] seen[$];
    logic [31:0] feed[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        vec++;
        if (act !== want) begin
            err++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (took && feed.size() != 0) void'(feed.pop_front());
        if (rst_n) begin
            chk("src_ready", 64'(src_ready), 64'(exp_ready));
            chk("re_valid", 64'(re_valid), 64'(exp_valid));
            chk("data_in", 64'(data_in), 64'(exp_data));
            chk("tx_busy", 64'(tx_busy), 64'(m_st != 0 || m_q.size() != 0));
            chk("stat_words", 64'(stat_words), STATS ? 64'(m_words) : 64'(0));
            chk("stat_stall", 64'(stat_stall_cycles), STATS ? 64'(m_stall) : 64'(0));
            chk("credit_inv", 64'(re_valid && re_credit == 0), 64'(0));
            if (re_valid) begin
                nval++;
                run++;
                seen.push_back(data_in);
            end else if (run != 0) begin
                runs.push_back(run);
                run = 0;
            end
        end
        src_valid = (feed.size() != 0);
        src_data  = (feed.size() != 0) ? feed[0] : '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        feed.delete();
        src_valid  = 1'b0;
        cred_limit = 1024;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        nval = 0; run = 0;
        runs.delete();
        seen.delete();
    endtask

    initial begin
        vec = 0; err = 0; nval = 0; run = 0;
        rst_n = 1'b1;
        src_valid = 1'b0; src_data = '0; cred_limit = 1024;
        src_valid2 = 1'b0; src_data2 = '0; cred2 = 11'd7;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_re_valid", 64'(re_valid), 64'(0));
        chk("rst_data_in", 64'(data_in), 64'(0));
        chk("rst_src_ready", 64'(src_ready), 64'(0));
        chk("rst_tx_busy", 64'(tx_busy), 64'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk("ready_after_release", 64'(src_ready), 64'(0));
        step();
        chk("ready_rises", 64'(src_ready), 64'(1));
        repeat (3) step();
        chk("idle_re_valid", 64'(re_valid), 64'(0));
        chk("idle_tx_busy", 64'(tx_busy), 64'(0));

        // BURST_MIN = 8 instance: 7 credits must not start a burst
        src_valid2 = 1'b1; src_data2 = 32'h0000_0077;
        step();
        src_valid2 = 1'b0;
        repeat (4) step();
        chk("bmin_hold_valid", 64'(re_valid2), 64'(0));
        chk("bmin_hold_busy", 64'(tx_busy2), 64'(1));
        cred2 = 11'd8;
        step();
        chk("bmin_start_valid", 64'(re_valid2), 64'(1));
        chk("bmin_start_data", 64'(data_in2), 64'h77);

        // single word: visible two edges after the accepting edge
        feed.push_back(32'hA5A5_0001);
        step();
        step();
        chk("single_lat1", 64'(re_valid), 64'(0));
        step();
        chk("single_valid", 64'(re_valid), 64'(1));
        chk("single_data", 64'(data_in), 64'hA5A5_0001);
        chk("single_busy", 64'(tx_busy), 64'(1));
        step();
        chk("single_gap", 64'(re_valid), 64'(0));
        chk("single_idle", 64'(tx_busy), 64'(0));

        // 40-word stream splits into 16/16/8
        runs.delete(); seen.delete(); run = 0;
        for (int i = 0; i < 40; i++) feed.push_back(32'h100 + 32'(i));
        for (int k = 0; k < 300 && (feed.size() != 0 || tx_busy || run != 0); k++) step();
        chk("burst_done", 64'(feed.size() == 0 && !tx_busy), 64'(1));
        chk("burst_count", 64'(runs.size()), 64'(3));
        chk("burst_len0", 64'(runs.size() > 0 ? runs[0] : 0), 64'(16));
        chk("burst_len1", 64'(runs.size() > 1 ? runs[1] : 0), 64'(16));
        chk("burst_len2", 64'(runs.size() > 2 ? runs[2] : 0), 64'(8));
        chk("burst_last", 64'(seen.size() == 40 ? seen[39] : 0), 64'h127);
        chk("burst_stat", 64'(stat_words), STATS ? 64'(41) : 64'(0));

        // credit starvation
        do_reset();
        cred_limit = 3;
        for (int i = 0; i < 8; i++) feed.push_back(32'h200 + 32'(i));
        repeat (20) step();
        chk("starve_issued", 64'(nval), 64'(3));
        chk("starve_ready", 64'(src_ready), 64'(0));
        chk("starve_busy", 64'(tx_busy), 64'(1));
        cred_limit = 8;
        for (int k = 0; k < 100 && (feed.size() != 0 || tx_busy); k++) step();
        chk("resume_issued", 64'(nval), 64'(8));
        chk("resume_order", 64'(seen.size() == 8 ? seen[3] : 0), 64'h203);
        chk("resume_last", 64'(seen.size() == 8 ? seen[7] : 0), 64'h207);

        // reset mid-burst
        do_reset();
        for (int i = 0; i < 10; i++) feed.push_back(32'h300 + 32'(i));
        for (int k = 0; k < 50 && nval < 5; k++) step();
        chk("mid_reached", 64'(nval), 64'(5));
        chk("mid_valid_before", 64'(re_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_drop", 64'(re_valid), 64'(0));
        chk("mid_async_busy", 64'(tx_busy), 64'(0));
        feed.delete();
        src_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        nval = 0;
        repeat (20) step();
        chk("mid_no_words", 64'(nval), 64'(0));
        chk("mid_idle", 64'(tx_busy), 64'(0));
        chk("mid_ready", 64'(src_ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/credit_tx.md
# credit_tx

Credit-based transmitter in the `re_clk` domain that feeds the write side of the cross-clock credit buffer. It accepts words from an upstream valid/ready stream into a small staging FIFO and drives `re_valid`/`data_in` into the buffer. A write is issued only when the buffer's advertised `re_credit` guarantees acceptance. Writes are grouped into bursts, bounded by minimum-credit and maximum-length rules, so no write is ever silently dropped downstream.

## Interface
Parameters:
- `DEPTH`, 1024 — depth of the downstream buffer; power of 2.
- `WIDTH`, 32 — data width in bits.
- `ADDR_W`, `$clog2(DEPTH)` — credit is `ADDR_W+1` bits.
- `STAGE_DEPTH`, 4 — local staging FIFO depth; power of 2, ≥2.
- `BURST_MIN`, 1 — effective credits required to start a burst; 1..DEPTH.
- `BURST_MAX`, 16 — maximum words per burst; ≥1.

Ports:
- `re_clk`  in  1  clock.
- `re_reset_n`  in  1  reset, asynchronous, active-low.
- `src_valid`  in  1  upstream word valid.
- `src_ready`  out  1  staging FIFO not full.
- `src_data`  in  WIDTH  upstream word.
- `re_credit`  in  ADDR_W+1  free space advertised by the buffer; combinational on the buffer's write pointer.
- `re_valid`  out  1  registered write strobe to the buffer.
- `data_in`  out  WIDTH  registered write data to the buffer.
- `tx_busy`  out  1  high when the FSM is not IDLE or the stage is non-empty.
- `stat_words`  out  32  words issued (see Configuration).
- `stat_stall_cycles`  out  32  cycles spent in STALL (see Configuration).

## Operation
- Staging FIFO:
  - Push when `src_valid && src_ready`.
  - `src_ready = (stage_cnt != STAGE_DEPTH)`, driven from registers only.
  - Push and pop in the same cycle are both allowed; the count is unchanged.
- Effective credit: `eff = re_credit - re_valid`, computed at `ADDR_W+1` bits. It subtracts the write that completes at the current edge. Because `re_credit` never decreases except through this block's own writes, `eff` never underflows.
- Issue condition: `issue = (stage_cnt != 0) && (eff >= 1)`.
  - On issue, pop the stage head into `data_in`, set `re_valid <= 1`, and increment `burst_cnt`.
  - Otherwise `re_valid <= 0`. `data_in` holds its last value.
- FSM states: IDLE, SEND, STALL, GAP.
  - IDLE: when `stage_cnt != 0 && eff >= BURST_MIN`, go to SEND and issue the first word at this same edge with `burst_cnt <= 1`.
  - SEND: issue every cycle while possible.
    - `burst_cnt == BURST_MAX`, or the stage empties after the pop → go to GAP.
    - `eff == 0` with stage non-empty → go to STALL with no issue.
  - STALL: no issue. When `eff >= 1`, go to SEND and issue.
  - GAP: exactly one idle cycle with `re_valid` low, then go to IDLE. This lets downstream arbitration observe burst boundaries.
- Invariant: `re_valid` is never high in a cycle where `re_credit == 0`. The buffer therefore accepts every strobed word.
- Word order is preserved end to end.

## Timing
- Reset (asynchronous, `re_reset_n` low):
  - `re_valid = 0`, `data_in = 0`, `src_ready = 0`, `tx_busy = 0`.
  - Stats are 0, the stage is emptied, the FSM is in IDLE, `burst_cnt = 0`.
  - `src_ready` rises in the first cycle after deassertion.
- Reset mid-burst: staged words are discarded, `re_valid` drops immediately, and no partial word is emitted.
- Latency: a word accepted at edge k with the FSM in IDLE and sufficient credit appears with `re_valid = 1` in the cycle following edge k+1, i.e. 2 cycles.
- Throughput: 1 word per cycle within a burst. The gap cycle costs 1 cycle per burst.
- Credit exhaustion:
  - When `re_credit` is 1 with `re_valid` high, `eff` is 0, so the next cycle stalls.
  - A credit return becomes visible 2–3 `re_clk` cycles after the reader consumes a word, due to the synchronizer. The block tolerates any delay.
- Stage full: `src_ready` is low. It rises the cycle after a pop that is not paired with a push.
- `burst_cnt` resets to 0 on entry to GAP. STALL does not reset it.

## Configuration
- `CREDIT_TX_STATS_EN` defined:
  - `stat_words` increments on every issued word and wraps at 2^32.
  - `stat_stall_cycles` increments on each cycle in STALL and wraps at 2^32.
  - Both are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

## Test plan
- Reset then idle: with `re_credit = 1024` and `src_valid = 0`, `re_valid` stays 0, `src_ready = 1`, and `tx_busy = 0`.
- Single word: push 0xA5A5_0001 with `re_credit = 1024` → `re_valid` high for 1 cycle, 2 cycles after the push, with `data_in = 0xA5A5_0001`; then 1 GAP cycle; `tx_busy` falls.
- Burst split: `BURST_MAX = 16`, stream of 40 words at full credit → bursts of 16, 16, 8 with one low `re_valid` cycle between them; `stat_words = 40` with the macro defined.
- Credit starvation: hold `re_credit = 3`, decrementing on writes, and push 8 words.
  - Exactly 3 words issue, then STALL; `src_ready` goes low once the stage fills.
  - Raising `re_credit` to 5 resumes issue in order.
  - `re_valid && re_credit == 0` is never observed.
- `BURST_MIN = 8` with `re_credit = 7` and the stage non-empty → no issue and the FSM stays in IDLE; `re_credit = 8` → the burst starts at the next edge.
- Reset asserted mid-burst after 5 of 10 words → `re_valid = 0` asynchronously; after release the stage is empty and no remaining words are emitted.
